// File: rtl/boot_pkg.sv
// -----------------------------------------------------------------------------
// boot_pkg
// Shared definitions for the UART boot loader: frame sync byte, frame field
// widths, the loader state encoding and the running-checksum helper.
// Optional feature macro: BOOT_CHECKSUM_EN (adds the CKSUM state).
// -----------------------------------------------------------------------------
package boot_pkg;

    localparam logic [7:0] SYNC_BYTE  = 8'hA5;
    localparam int         BYTE_W     = 8;
    localparam int         LEN_W      = 16;
    localparam int         WORD_W     = 32;
    localparam int         BYTE_CNT_W = 2;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LEN0  = 3'd1,
        LEN1  = 3'd2,
        DATA  = 3'd3,
`ifdef BOOT_CHECKSUM_EN
        CKSUM = 3'd4,
`endif
        DONE  = 3'd5,
        ERR   = 3'd6
    } boot_state_t;

    // Running XOR over frame bytes.
    function automatic logic [BYTE_W-1:0] cksum_update(
        input logic [BYTE_W-1:0] acc,
        input logic [BYTE_W-1:0] data
    );
        return acc ^ data;
    endfunction

endpackage

// File: rtl/boot_timeout.sv
// -----------------------------------------------------------------------------
// boot_timeout
// Loadable down-counter that flags when TIMEOUT_CYC cycles have elapsed since
// the last load while enabled.
// Ports:
//   clk, reset_n  - system clock, synchronous active-low reset
//   load          - reload the counter (a byte arrived)
//   enable        - count only while a frame is in progress
//   expired       - the next idle edge is the TIMEOUT_CYC-th one; a load in
//                   the same cycle suppresses it
// -----------------------------------------------------------------------------
module boot_timeout #(
    parameter int unsigned TIMEOUT_CYC = 1_000_000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic load,
    input  logic enable,
    output logic expired
);

    localparam int             CNT_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

    logic [CNT_W-1:0] cnt_r;

    // Down-counter: loaded on every byte, decremented on idle enabled cycles.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_r <= '0;
        end else if (load) begin
            cnt_r <= LOAD_VAL;
        end else if (enable && (cnt_r != '0)) begin
            cnt_r <= cnt_r - ONE;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // A counter value of one means this cycle's edge completes the idle window.
    assign expired = enable && !load && (cnt_r == ONE);

endmodule

// File: rtl/uart_boot_loader.sv
// -----------------------------------------------------------------------------
// uart_boot_loader
// Receives a boot frame from the UART RX byte stream and writes it into the
// instruction memory, holding the core in reset until a load completes.
// Frame: A5, LEN_LO, LEN_HI, 4*N little-endian data bytes [, CKSUM].
// Optional feature macro: BOOT_CHECKSUM_EN -- when defined, a trailing XOR
// checksum over the LEN and data bytes is verified before DONE.
// Ports:
//   clk, reset_n          - system clock, synchronous active-low reset
//   rx_data, rx_valid     - byte and one-cycle strobe from the UART receiver
//   mem_we/addr/wdata     - instruction-memory write port (values held when idle)
//   cpu_reset_n           - core reset, released once a load completes
//   boot_done, boot_err   - load completed / last frame aborted
// -----------------------------------------------------------------------------
module uart_boot_loader
    import boot_pkg::*;
#(
    parameter int unsigned ADDR_W      = 7,
    parameter int unsigned TIMEOUT_CYC = 1_000_000
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_reset_n,
    output logic              boot_done,
    output logic              boot_err
);

    // One extra bit so a full 2**ADDR_W word load can be counted.
    localparam int               IDX_W     = ADDR_W + 1;
    localparam logic [LEN_W-1:0] MAX_WORDS = LEN_W'(2 ** ADDR_W);

    boot_state_t             state_r;
    logic [LEN_W-1:0]        len_r;
    logic [WORD_W-1:0]       word_r;
    logic [BYTE_CNT_W-1:0]   byte_cnt_r;
    logic [IDX_W-1:0]        word_idx_r;
    logic                    mem_we_r;
    logic [ADDR_W-1:0]       mem_addr_r;
    logic [WORD_W-1:0]       mem_wdata_r;
    logic                    cpu_reset_n_r;
    logic                    boot_done_r;
    logic                    boot_err_r;
`ifdef BOOT_CHECKSUM_EN
    logic [BYTE_W-1:0]       xor_r;
`endif

    logic [LEN_W-1:0]        len_full_s;
    logic [IDX_W-1:0]        next_idx_s;
    logic                    sync_s;
    logic                    tmo_en_s;
    logic                    tmo_expired_s;

    assign len_full_s = {rx_data, len_r[7:0]};
    assign next_idx_s = word_idx_r + IDX_W'(1);
    assign sync_s     = rx_valid && (rx_data == SYNC_BYTE);

    // Timeout runs only while a frame is in progress.
    always_comb begin
        tmo_en_s = 1'b0;
        case (state_r)
            LEN0, LEN1, DATA: tmo_en_s = 1'b1;
`ifdef BOOT_CHECKSUM_EN
            CKSUM:            tmo_en_s = 1'b1;
`endif
            default:          tmo_en_s = 1'b0;
        endcase
    end

    boot_timeout #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timeout (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (rx_valid),
        .enable  (tmo_en_s),
        .expired (tmo_expired_s)
    );

    // Frame FSM with registered memory-port and status outputs.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r       <= IDLE;
            len_r         <= '0;
            word_r        <= '0;
            byte_cnt_r    <= '0;
            word_idx_r    <= '0;
            mem_we_r      <= 1'b0;
            mem_addr_r    <= '0;
            mem_wdata_r   <= '0;
            cpu_reset_n_r <= 1'b0;
            boot_done_r   <= 1'b0;
            boot_err_r    <= 1'b0;
`ifdef BOOT_CHECKSUM_EN
            xor_r         <= '0;
`endif
        end else begin
            mem_we_r <= 1'b0;
            case (state_r)
                IDLE, ERR: begin
                    // Sync starts a fresh frame; from ERR this is a re-load.
                    if (sync_s) begin
                        state_r    <= LEN0;
                        len_r      <= '0;
                        word_r     <= '0;
                        byte_cnt_r <= '0;
                        word_idx_r <= '0;
                        boot_err_r <= 1'b0;
`ifdef BOOT_CHECKSUM_EN
                        xor_r      <= '0;
`endif
                    end
                end
                LEN0: begin
                    if (rx_valid) begin
                        len_r[7:0] <= rx_data;
                        state_r    <= LEN1;
`ifdef BOOT_CHECKSUM_EN
                        xor_r      <= cksum_update(xor_r, rx_data);
`endif
                    end else if (tmo_expired_s) begin
                        state_r    <= ERR;
                        boot_err_r <= 1'b1;
                    end
                end
                LEN1: begin
                    if (rx_valid) begin
                        len_r[15:8] <= rx_data;
`ifdef BOOT_CHECKSUM_EN
                        xor_r       <= cksum_update(xor_r, rx_data);
`endif
                        if (len_full_s > MAX_WORDS) begin
                            state_r    <= ERR;
                            boot_err_r <= 1'b1;
                        end else if (len_full_s == LEN_W'(0)) begin
`ifdef BOOT_CHECKSUM_EN
                            state_r       <= CKSUM;
`else
                            state_r       <= DONE;
                            boot_done_r   <= 1'b1;
                            cpu_reset_n_r <= 1'b1;
`endif
                        end else begin
                            state_r <= DATA;
                        end
                    end else if (tmo_expired_s) begin
                        state_r    <= ERR;
                        boot_err_r <= 1'b1;
                    end
                end
                DATA: begin
`ifndef BOOT_CHECKSUM_EN
                    // Last word was written on the previous edge; finish now.
                    if (LEN_W'(word_idx_r) == len_r) begin
                        state_r       <= DONE;
                        boot_done_r   <= 1'b1;
                        cpu_reset_n_r <= 1'b1;
                    end else
`endif
                    if (rx_valid) begin
                        // Bytes enter at the top so the first byte ends up in [7:0].
                        word_r     <= {rx_data, word_r[31:8]};
                        byte_cnt_r <= byte_cnt_r + 2'd1;
`ifdef BOOT_CHECKSUM_EN
                        xor_r      <= cksum_update(xor_r, rx_data);
`endif
                        if (byte_cnt_r == 2'd3) begin
                            mem_we_r    <= 1'b1;
                            mem_addr_r  <= word_idx_r[ADDR_W-1:0];
                            mem_wdata_r <= {rx_data, word_r[31:8]};
                            word_idx_r  <= next_idx_s;
`ifdef BOOT_CHECKSUM_EN
                            // Move on immediately so a back-to-back checksum byte is caught.
                            if (LEN_W'(next_idx_s) == len_r) begin
                                state_r <= CKSUM;
                            end
`endif
                        end
                    end else if (tmo_expired_s) begin
                        state_r    <= ERR;
                        boot_err_r <= 1'b1;
                    end
                end
`ifdef BOOT_CHECKSUM_EN
                CKSUM: begin
                    if (rx_valid) begin
                        if (rx_data == xor_r) begin
                            state_r       <= DONE;
                            boot_done_r   <= 1'b1;
                            cpu_reset_n_r <= 1'b1;
                        end else begin
                            state_r    <= ERR;
                            boot_err_r <= 1'b1;
                        end
                    end else if (tmo_expired_s) begin
                        state_r    <= ERR;
                        boot_err_r <= 1'b1;
                    end
                end
`endif
                DONE: begin
                    state_r <= DONE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign mem_we      = mem_we_r;
    assign mem_addr    = mem_addr_r;
    assign mem_wdata   = mem_wdata_r;
    assign cpu_reset_n = cpu_reset_n_r;
    assign boot_done   = boot_done_r;
    assign boot_err    = boot_err_r;

endmodule
